// File: rtl/exec_pkg.sv
// Shared types and constants for the RV32 execute stage (ALU ops, forwarding,
// divide ops, branch funct3 codes, divider FSM states).
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RD      = 2'd0,
    FWD_RESULTW = 2'd1,
    FWD_ALURESM = 2'd2,
    FWD_RD_ALT  = 2'd3
  } fwd_sel_t;

  typedef enum logic [1:0] {
    DIV_S  = 2'd0,
    DIV_U  = 2'd1,
    REM_S  = 2'd2,
    REM_U  = 2'd3
  } div_op_t;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic is_signed_div(input logic [1:0] op);
    return (op == DIV_S) || (op == REM_S);
  endfunction

endpackage

// File: rtl/execute_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN skips the iteration when the answer is trivial.
module div_unit
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_advance,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ALL_ZERO = {DATA_WIDTH{1'b0}};

  div_state_t            r_state;
  div_state_t            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_div;
  logic [1:0]            r_op;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_div_zero;

  logic                  w_load;
  logic                  w_early;
  logic                  w_sa;
  logic                  w_sb;
  logic [DATA_WIDTH-1:0] w_a_abs;
  logic [DATA_WIDTH-1:0] w_b_abs;
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH:0]   w_trial;
  logic [DATA_WIDTH-1:0] w_quo_fix;
  logic [DATA_WIDTH-1:0] w_rem_fix;

  assign w_sa    = is_signed_div(i_op) & i_dividend[DATA_WIDTH-1];
  assign w_sb    = is_signed_div(i_op) & i_divisor[DATA_WIDTH-1];
  assign w_a_abs = w_sa ? -i_dividend : i_dividend;
  assign w_b_abs = w_sb ? -i_divisor : i_divisor;
  assign w_shift = {r_rem, r_quo[DATA_WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_div};

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_b_abs == ALL_ZERO) || (w_a_abs < w_b_abs);
`else
  assign w_early = 1'b0;
`endif

  // Next-state logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          w_load      = 1'b1;
          w_state_nxt = w_early ? DONE : RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (i_abort) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (i_abort || i_advance) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, operand latch and one restoring step per RUN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_quo      <= ALL_ZERO;
      r_rem      <= ALL_ZERO;
      r_div      <= ALL_ZERO;
      r_op       <= 2'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cnt      <= {CNT_W{1'b0}};
        r_div      <= w_b_abs;
        r_op       <= i_op;
        r_neg_q    <= w_sa ^ w_sb;
        r_neg_r    <= w_sa;
        r_div_zero <= (i_divisor == ALL_ZERO);
        // Early exit leaves the operands already in final quotient/remainder form
        r_quo      <= w_early ? ALL_ZERO : w_a_abs;
        r_rem      <= w_early ? w_a_abs : ALL_ZERO;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        r_quo <= {r_quo[DATA_WIDTH-2:0], ~w_trial[DATA_WIDTH]};
        r_rem <= w_trial[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
      end
    end
  end

  assign w_quo_fix = r_div_zero ? ALL_ONES : (r_neg_q ? -r_quo : r_quo);
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  // Result selection by latched operation
  always_comb begin
    o_result = w_rem_fix;
    case (r_op)
      DIV_S, DIV_U: o_result = w_quo_fix;
      default:      o_result = w_rem_fix;
    endcase
  end

  assign o_busy = i_start & (r_state != DONE);
  assign o_done = (r_state == DONE);

endmodule

// File: rtl/execute_top.sv
// RV32 execute stage: forwarding, ALU, branch resolution, multi-cycle divider
// and the E/M pipeline register. Optional macro: DIV_EARLY_OUT_EN.
module execute_top
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic                  JumpE,
  input  logic                  BranchE,
  input  logic                  JalrE,
  input  logic                  ALUSrcE,
  input  logic                  DivE,
  input  logic [1:0]            ResultSrcE,
  input  logic [2:0]            MemoryOpE,
  input  logic [2:0]            BranchOpE,
  input  logic [3:0]            ALUControlE,
  input  logic [1:0]            DivOpE,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [DATA_WIDTH-1:0] RD1E,
  input  logic [DATA_WIDTH-1:0] RD2E,
  input  logic [DATA_WIDTH-1:0] ImmExtE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] PCPlus4E,
  input  logic [4:0]            RdE,
  input  logic [DATA_WIDTH-1:0] ResultW,
  output logic                  PCSrcE,
  output logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  DivBusyE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultsSrcM,
  output logic [2:0]            MemoryOpM,
  output logic [DATA_WIDTH-1:0] ALUResultM,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic [4:0]            RdM
);

  localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] LSB_MASK = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  logic [DATA_WIDTH-1:0] w_src_a;
  logic [DATA_WIDTH-1:0] w_write_data;
  logic [DATA_WIDTH-1:0] w_src_b;
  logic [4:0]            w_shamt;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_eq;
  logic                  w_lt;
  logic                  w_ltu;
  logic                  w_cond;
  logic                  w_div_busy;
  logic                  w_div_done;
  logic [DATA_WIDTH-1:0] w_div_result;

  logic                  r_reg_write;
  logic                  r_mem_write;
  logic [1:0]            r_result_src;
  logic [2:0]            r_mem_op;
  logic [DATA_WIDTH-1:0] r_alu_result;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic [DATA_WIDTH-1:0] r_pc_plus4;
  logic [4:0]            r_rd;

  // Operand forwarding; select 3 falls back to the register file value
  always_comb begin
    w_src_a      = RD1E;
    w_write_data = RD2E;
    case (ForwardAE)
      FWD_RESULTW: w_src_a = ResultW;
      FWD_ALURESM: w_src_a = r_alu_result;
      default:     w_src_a = RD1E;
    endcase
    case (ForwardBE)
      FWD_RESULTW: w_write_data = ResultW;
      FWD_ALURESM: w_write_data = r_alu_result;
      default:     w_write_data = RD2E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ImmExtE : w_write_data;
  assign w_shamt = w_src_b[4:0];

  // Single-cycle ALU
  always_comb begin
    w_alu = ZERO_W;
    case (ALUControlE)
      ALU_ADD:   w_alu = w_src_a + w_src_b;
      ALU_SUB:   w_alu = w_src_a - w_src_b;
      ALU_AND:   w_alu = w_src_a & w_src_b;
      ALU_OR:    w_alu = w_src_a | w_src_b;
      ALU_XOR:   w_alu = w_src_a ^ w_src_b;
      ALU_SLL:   w_alu = w_src_a << w_shamt;
      ALU_SRL:   w_alu = w_src_a >> w_shamt;
      ALU_SRA:   w_alu = $signed(w_src_a) >>> w_shamt;
      ALU_SLT:   w_alu = {{(DATA_WIDTH-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
      ALU_SLTU:  w_alu = {{(DATA_WIDTH-1){1'b0}}, w_src_a < w_src_b};
      ALU_PASSB: w_alu = w_src_b;
      default:   w_alu = ZERO_W;
    endcase
  end

  assign w_eq  = (w_src_a == w_write_data);
  assign w_lt  = ($signed(w_src_a) < $signed(w_write_data));
  assign w_ltu = (w_src_a < w_write_data);

  // Branch condition decode
  always_comb begin
    w_cond = 1'b0;
    case (BranchOpE)
      BR_BEQ:  w_cond = w_eq;
      BR_BNE:  w_cond = ~w_eq;
      BR_BLT:  w_cond = w_lt;
      BR_BGE:  w_cond = ~w_lt;
      BR_BLTU: w_cond = w_ltu;
      BR_BGEU: w_cond = ~w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  assign PCSrcE    = JumpE | (BranchE & w_cond);
  assign PCTargetE = JalrE ? ((w_src_a + ImmExtE) & LSB_MASK) : (PCE + ImmExtE);

  div_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (DivE),
    .i_abort    (flush),
    .i_advance  (~stall),
    .i_op       (DivOpE),
    .i_dividend (w_src_a),
    .i_divisor  (w_write_data),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_result   (w_div_result)
  );

  assign DivBusyE = w_div_busy;
  assign w_result = (DivE && w_div_done) ? w_div_result : w_alu;

  // E/M pipeline register: flush > divider bubble > stall hold > load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 2'd0;
      r_mem_op     <= 3'd0;
      r_alu_result <= ZERO_W;
      r_write_data <= ZERO_W;
      r_pc_plus4   <= ZERO_W;
      r_rd         <= 5'd0;
    end else if (flush || (w_div_busy && !stall)) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 2'd0;
      r_mem_op     <= 3'd0;
      r_alu_result <= ZERO_W;
      r_write_data <= ZERO_W;
      r_pc_plus4   <= ZERO_W;
      r_rd         <= 5'd0;
    end else if (!stall) begin
      r_reg_write  <= RegWriteE;
      r_mem_write  <= MemWriteE;
      r_result_src <= ResultSrcE;
      r_mem_op     <= MemoryOpE;
      r_alu_result <= w_result;
      r_write_data <= w_write_data;
      r_pc_plus4   <= PCPlus4E;
      r_rd         <= RdE;
    end
  end

  assign RegWriteM   = r_reg_write;
  assign MemWriteM   = r_mem_write;
  assign ResultsSrcM = r_result_src;
  assign MemoryOpM   = r_mem_op;
  assign ALUResultM  = r_alu_result;
  assign WriteDataM  = r_write_data;
  assign PCPlus4M    = r_pc_plus4;
  assign RdM         = r_rd;

endmodule

// File: tb/tb_execute_top.sv
// Scoreboard bench for execute_top: stimulus pushes expected write-backs, a
// negedge monitor pops and compares whenever a new register write reaches M.
module tb_execute_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, DivE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  MemoryOpE, BranchOpE;
  logic [3:0]  ALUControlE;
  logic [1:0]  DivOpE, ForwardAE, ForwardBE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic        PCSrcE, DivBusyE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultsSrcM;
  logic [2:0]  MemoryOpM;
  logic [4:0]  RdM;

  int tests = 0;
  int fails = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic [31:0] q_val[$];
  logic [4:0]  q_rd[$];
  string       q_nm[$];
  logic        last_stall = 1'b0;

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        src;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] rw;
    logic [31:0] exp;
  } alu_vec_t;

  execute_top dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .JalrE(JalrE), .ALUSrcE(ALUSrcE), .DivE(DivE), .ResultSrcE(ResultSrcE),
    .MemoryOpE(MemoryOpE), .BranchOpE(BranchOpE), .ALUControlE(ALUControlE),
    .DivOpE(DivOpE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .DivBusyE(DivBusyE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultsSrcM(ResultsSrcM), .MemoryOpM(MemoryOpM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  always #5 clk = ~clk;

  always @(posedge clk) last_stall <= stall;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: a freshly loaded register write in M consumes one scoreboard entry
  logic [31:0] m_val;
  logic [4:0]  m_rd;
  string       m_nm;
  always @(negedge clk) begin
    if (reset && RegWriteM && !last_stall) begin
      if (q_val.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got rd %0d value %h expected no write", RdM, ALUResultM);
      end else begin
        m_val = q_val.pop_front();
        m_rd  = q_rd.pop_front();
        m_nm  = q_nm.pop_front();
        check(m_nm, ALUResultM, m_val);
        check({m_nm, "_rd"}, {27'd0, RdM}, {27'd0, m_rd});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0;
    RegWriteE = 1'b0; MemWriteE = 1'b0; JumpE = 1'b0; BranchE = 1'b0;
    JalrE = 1'b0; ALUSrcE = 1'b0; DivE = 1'b0;
    ResultSrcE = 2'd0; MemoryOpE = 3'd0; BranchOpE = 3'd0; ALUControlE = 4'd0;
    DivOpE = 2'd0; ForwardAE = 2'd0; ForwardBE = 2'd0;
    RD1E = 32'd0; RD2E = 32'd0; ImmExtE = 32'd0; PCE = 32'd0; PCPlus4E = 32'd0;
    RdE = 5'd0; ResultW = 32'd0;
  endtask

  task automatic drive_alu(input alu_vec_t v, input logic [4:0] rd);
    clear_inputs();
    RegWriteE = 1'b1; ALUControlE = v.op; ForwardAE = v.fa; ForwardBE = v.fb;
    ALUSrcE = v.src; RD1E = v.rd1; RD2E = v.rd2; ImmExtE = v.imm; ResultW = v.rw;
    RdE = rd;
  endtask

  task automatic issue_alu(input alu_vec_t v, input logic [4:0] rd, input string nm);
    drive_alu(v, rd);
    q_val.push_back(v.exp); q_rd.push_back(rd); q_nm.push_back(nm);
    tick();
  endtask

  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit early_case, input string nm);
    int cnt;
    int exp_busy;
    exp_busy = (early_case && EARLY) ? 1 : 33;
    clear_inputs();
    DivE = 1'b1; DivOpE = op; RD1E = a; RD2E = b; RegWriteE = 1'b1; RdE = 5'd10;
    q_val.push_back(exp); q_rd.push_back(5'd10); q_nm.push_back(nm);
    #1;
    cnt = 0;
    while (DivBusyE === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == 2) check({nm, "_bubble"}, {26'd0, RegWriteM, RdM}, 32'd0);
      @(posedge clk);
      #2;
    end
    check({nm, "_busy_cycles"}, cnt, exp_busy);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  alu_vec_t vecs[$];
  alu_vec_t v;

  initial begin
    clear_inputs();
    reset = 1'b0;
    #3;
    check("reset_alu", ALUResultM, 32'd0);
    check("reset_ctl", {25'd0, RegWriteM, MemWriteM, ResultsSrcM, MemoryOpM}, 32'd0);
    check("reset_rd", {27'd0, RdM}, 32'd0);
    check("reset_busy", {31'd0, DivBusyE}, 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // ADD with forwarded ResultW and negative immediate, then stall holds it
    v = '{op:4'd0, fa:2'd1, fb:2'd0, src:1'b1, rd1:32'd5, rd2:32'd0,
          imm:32'hFFFF_FFFD, rw:32'd7, exp:32'd4};
    issue_alu(v, 5'd1, "add_fwd_resultw");
    v = '{op:4'd0, fa:2'd3, fb:2'd0, src:1'b0, rd1:32'd100, rd2:32'd0,
          imm:32'd0, rw:32'd0, exp:32'd100};
    drive_alu(v, 5'd2);
    stall = 1'b1;
    tick(); tick();
    check("stall_hold_alu", ALUResultM, 32'd4);
    check("stall_hold_rd", {27'd0, RdM}, 32'd1);
    clear_inputs();
    tick();

    vecs.push_back('{4'd1,  2'd0, 2'd0, 1'b0, 32'd10,         32'd3,          32'd0,          32'd0,          32'd7});
    vecs.push_back('{4'd2,  2'd0, 2'd0, 1'b0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,          32'd0,          32'h00F0_00F0});
    vecs.push_back('{4'd3,  2'd0, 2'd0, 1'b0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,          32'd0,          32'hFFF0_FFF0});
    vecs.push_back('{4'd4,  2'd0, 2'd0, 1'b0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,          32'd0,          32'hFF00_FF00});
    vecs.push_back('{4'd5,  2'd0, 2'd0, 1'b1, 32'd1,          32'd0,          32'h21,         32'd0,          32'd2});
    vecs.push_back('{4'd6,  2'd0, 2'd0, 1'b1, 32'h8000_0000,  32'd0,          32'd31,         32'd0,          32'd1});
    vecs.push_back('{4'd7,  2'd0, 2'd0, 1'b1, 32'h8000_0000,  32'd0,          32'd4,          32'd0,          32'hF800_0000});
    vecs.push_back('{4'd8,  2'd0, 2'd0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0,          32'd1});
    vecs.push_back('{4'd9,  2'd0, 2'd0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0,          32'd0});
    vecs.push_back('{4'd0,  2'd0, 2'd0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0,          32'd0});
    vecs.push_back('{4'd8,  2'd0, 2'd1, 1'b0, 32'd5,          32'd0,          32'd0,          32'hFFFF_FFF0,  32'd0});
    vecs.push_back('{4'd10, 2'd0, 2'd0, 1'b1, 32'd0,          32'd0,          32'h1234_5000,  32'd0,          32'h1234_5000});
    vecs.push_back('{4'd0,  2'd3, 2'd2, 1'b0, 32'd1,          32'hDEAD_BEEF,  32'd0,          32'd0,          32'h1234_5001});
    foreach (vecs[i]) issue_alu(vecs[i], 5'(i + 2), $sformatf("alu_vec%0d", i));
    clear_inputs();
    tick();

    // Branch and jump resolution: {BranchE, JumpE, JalrE, funct3, rd1, rd2, pc, imm, src, target}
    begin
      logic [3:0]  bctl [8];
      logic [2:0]  bop  [8];
      logic [31:0] ba   [8];
      logic [31:0] bb   [8];
      logic [31:0] bpc  [8];
      logic [31:0] bimm [8];
      logic        bsrc [8];
      logic [31:0] btgt [8];
      bctl = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0110, 4'b0100};
      bop  = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd0, 3'd0};
      ba   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h55, 32'h55, 32'h203, 32'd0};
      bb   = '{32'd1, 32'd1, 32'd1, 32'd1, 32'h55, 32'h55, 32'd0, 32'd0};
      bpc  = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h200, 32'h300, 32'h400};
      bimm = '{32'h20, 32'h20, 32'h20, 32'h20, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'd0, 32'h8};
      bsrc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      btgt = '{32'h120, 32'h120, 32'h120, 32'h120, 32'h1F0, 32'h1F0, 32'h202, 32'h408};
      for (int i = 0; i < 8; i++) begin
        clear_inputs();
        BranchE = bctl[i][3]; JumpE = bctl[i][2]; JalrE = bctl[i][1];
        BranchOpE = bop[i]; RD1E = ba[i]; RD2E = bb[i]; PCE = bpc[i]; ImmExtE = bimm[i];
        #1;
        check($sformatf("br%0d_pcsrc", i), {31'd0, PCSrcE}, {31'd0, bsrc[i]});
        check($sformatf("br%0d_target", i), PCTargetE, btgt[i]);
        tick();
      end
    end
    clear_inputs();
    tick();

    // Divides: ops 0 DIV, 1 DIVU, 2 REM, 3 REMU
    do_div(2'd0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2");
    do_div(2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, "rem_m7_2");
    do_div(2'd1, 32'd7,         32'd2,         32'd3,         1'b0, "divu_7_2");
    do_div(2'd0, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "div_5_0");
    do_div(2'd2, 32'd5,         32'd0,         32'd5,         1'b1, "rem_5_0");
    do_div(2'd0, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b1, "div_m7_0");
    do_div(2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b1, "rem_m7_0");
    do_div(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf");
    do_div(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, "rem_ovf");
    do_div(2'd1, 32'd3,         32'd10,        32'd0,         1'b1, "divu_3_10");
    do_div(2'd3, 32'd3,         32'd10,        32'd3,         1'b1, "remu_3_10");
    tick();

    // Flush beats stall and clears M
    v = '{op:4'd0, fa:2'd0, fb:2'd0, src:1'b1, rd1:32'd1, rd2:32'd0,
          imm:32'd1, rw:32'd0, exp:32'd2};
    issue_alu(v, 5'd7, "add_before_flush");
    v.rd1 = 32'd50;
    drive_alu(v, 5'd9);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_alu", ALUResultM, 32'd0);
    check("flush_ctl", {26'd0, RegWriteM, RdM}, 32'd0);
    clear_inputs();
    tick();

    // Flush mid-divide aborts; a following divide starts from IDLE
    clear_inputs();
    DivE = 1'b1; DivOpE = 2'd0; RD1E = 32'hFFFF_FFF9; RD2E = 32'd2; RegWriteE = 1'b1; RdE = 5'd11;
    for (int i = 0; i < 11; i++) tick();
    check("busy_before_flush", {31'd0, DivBusyE}, 32'd1);
    flush = 1'b1;
    tick();
    clear_inputs();
    #1;
    check("flush_div_busy", {31'd0, DivBusyE}, 32'd0);
    check("flush_div_m", {26'd0, RegWriteM, RdM}, 32'd0);
    do_div(2'd1, 32'd7, 32'd2, 32'd3, 1'b0, "divu_after_flush");

    // Async reset mid-RUN while M is held by stall
    v = '{op:4'd3, fa:2'd0, fb:2'd0, src:1'b1, rd1:32'hA000_0000, rd2:32'd0,
          imm:32'h5, rw:32'd0, exp:32'hA000_0005};
    issue_alu(v, 5'd3, "or_before_reset");
    clear_inputs();
    DivE = 1'b1; DivOpE = 2'd0; RD1E = 32'd100; RD2E = 32'd3; RegWriteE = 1'b1; RdE = 5'd12;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("stall_during_div", ALUResultM, 32'hA000_0005);
    #1;
    clear_inputs();
    reset = 1'b0;
    #1;
    check("async_reset_alu", ALUResultM, 32'd0);
    check("async_reset_ctl", {26'd0, RegWriteM, RdM}, 32'd0);
    check("async_reset_busy", {31'd0, DivBusyE}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    do_div(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_after_reset");

    tick(); tick();
    check("scoreboard_empty", q_val.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
